// File: rtl/keypad_entry_if.sv
// Committed-value handshake between the keypad entry block and the arming logic.
// The producer holds commit_valid/commit_bcd until a clock edge where commit_ready is also high.
interface keypad_entry_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      commit_valid;
    logic [4*NUM_DIGITS-1:0]   commit_bcd;
    logic                      commit_ready;

    modport master (
        output commit_valid,
        output commit_bcd,
        input  commit_ready
    );

    modport slave (
        input  commit_valid,
        input  commit_bcd,
        output commit_ready
    );
endinterface

// File: rtl/keypad_entry.sv
// Keypad entry: debounces scanner codes, detects presses, builds a BCD entry with
// backspace/commit, hands the committed value off over valid/ready and times out idle entries.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int NUM_DIGITS      = 4,
    parameter int TIMEOUT_CYCLES  = 480000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4:0]              key,
    output logic [4*NUM_DIGITS-1:0] entry_bcd,
    output logic [3:0]              entry_len,
    keypad_entry_if.master          commit,
    output logic                    key_event,
    output logic                    err_event,
    output logic                    timeout_event
);
    localparam int               W      = 4 * NUM_DIGITS;
    localparam int               DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      TO_MAX = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LEN_MAX = 4'(NUM_DIGITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [4:0] KEY_NONE = 5'h00;
    localparam logic [4:0] KEY_STAR = 5'h1A;

    function automatic logic is_valid_code(input logic [4:0] code);
        return (code >= 5'h10) && (code <= 5'h1B);
    endfunction

    function automatic logic is_digit_code(input logic [4:0] code);
        return (code >= 5'h10) && (code <= 5'h19);
    endfunction

    logic [4:0]      cand_r;
    logic [DB_W-1:0] db_cnt_r;
    logic [4:0]      stable_r;
    logic [4:0]      prev_stable_r;
    logic            press_r;
    logic [4:0]      press_code_r;

    logic [1:0]      state_r;
    logic [W-1:0]    entry_bcd_r;
    logic [3:0]      entry_len_r;
    logic            commit_valid_r;
    logic [W-1:0]    commit_bcd_r;
    logic            key_event_r;
    logic            err_event_r;
    logic            timeout_event_r;
    logic [31:0]     idle_cnt_r;

    logic [1:0]      state_s;
    logic [W-1:0]    entry_bcd_s;
    logic [3:0]      entry_len_s;
    logic            commit_valid_s;
    logic [W-1:0]    commit_bcd_s;
    logic            key_event_s;
    logic            err_event_s;
    logic            timeout_event_s;
    logic [31:0]     idle_cnt_s;
    logic            valid_press_s;

    // Debounce: a code must persist DEBOUNCE_CYCLES samples before it becomes stable_r.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_r   <= 5'h00;
            db_cnt_r <= '0;
            stable_r <= 5'h00;
        end else begin
            if (key != cand_r) begin
                cand_r   <= key;
                db_cnt_r <= '0;
            end else if (db_cnt_r != DB_MAX) begin
                db_cnt_r <= db_cnt_r + 1'b1;
            end else begin
                db_cnt_r <= db_cnt_r;
            end
            if (db_cnt_r == DB_MAX) begin
                stable_r <= cand_r;
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    // Press edge: only a release-to-code transition of the stable key counts as a press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_stable_r <= 5'h00;
            press_r       <= 1'b0;
            press_code_r  <= 5'h00;
        end else begin
            prev_stable_r <= stable_r;
            press_r       <= (prev_stable_r == KEY_NONE) && (stable_r != KEY_NONE);
            press_code_r  <= stable_r;
        end
    end

    assign valid_press_s = press_r && is_valid_code(press_code_r);

    // Next-state and next-output logic for the entry FSM and idle timer.
    always_comb begin
        state_s         = state_r;
        entry_bcd_s     = entry_bcd_r;
        entry_len_s     = entry_len_r;
        commit_valid_s  = commit_valid_r;
        commit_bcd_s    = commit_bcd_r;
        key_event_s     = 1'b0;
        err_event_s     = 1'b0;
        timeout_event_s = 1'b0;
        idle_cnt_s      = 32'd0;
        case (state_r)
            ST_IDLE, ST_ENTRY: begin
                if (valid_press_s) begin
                    if (is_digit_code(press_code_r)) begin
                        if (entry_len_r < LEN_MAX) begin
                            entry_bcd_s = (entry_bcd_r << 4) | W'(press_code_r[3:0]);
                            entry_len_s = entry_len_r + 4'd1;
                            key_event_s = 1'b1;
                            state_s     = ST_ENTRY;
                        end else begin
                            err_event_s = 1'b1;
                        end
                    end else if (press_code_r == KEY_STAR) begin
                        if (entry_len_r != 4'd0) begin
                            entry_bcd_s = entry_bcd_r >> 4;
                            entry_len_s = entry_len_r - 4'd1;
                            key_event_s = 1'b1;
                            if (entry_len_r == 4'd1) begin
                                state_s = ST_IDLE;
                            end else begin
                                state_s = ST_ENTRY;
                            end
                        end else begin
                            err_event_s = 1'b1;
                        end
                    end else begin
                        if (state_r == ST_ENTRY) begin
                            commit_bcd_s   = entry_bcd_r;
                            commit_valid_s = 1'b1;
                            entry_bcd_s    = '0;
                            entry_len_s    = 4'd0;
                            key_event_s    = 1'b1;
                            state_s        = ST_HOLD;
                        end else begin
                            err_event_s = 1'b1;
                        end
                    end
                end else if (state_r == ST_ENTRY) begin
                    // A press on the timeout cycle takes priority, so the timeout sits in this else.
                    if (idle_cnt_r == TO_MAX) begin
                        entry_bcd_s     = '0;
                        entry_len_s     = 4'd0;
                        timeout_event_s = 1'b1;
                        state_s         = ST_IDLE;
                    end else begin
                        idle_cnt_s = idle_cnt_r + 32'd1;
                    end
                end else begin
                    idle_cnt_s = 32'd0;
                end
            end
            ST_HOLD: begin
                if (valid_press_s) begin
                    err_event_s = 1'b1;
                end else begin
                    err_event_s = 1'b0;
                end
                if (commit_valid_r && commit.commit_ready) begin
                    commit_valid_s = 1'b0;
                    state_s        = ST_IDLE;
                end else begin
                    commit_valid_s = commit_valid_r;
                end
            end
            default: begin
                state_s        = ST_IDLE;
                entry_bcd_s    = '0;
                entry_len_s    = 4'd0;
                commit_valid_s = 1'b0;
                commit_bcd_s   = '0;
            end
        endcase
    end

    // Register FSM state, entry, commit handshake and event pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            entry_bcd_r     <= '0;
            entry_len_r     <= 4'd0;
            commit_valid_r  <= 1'b0;
            commit_bcd_r    <= '0;
            key_event_r     <= 1'b0;
            err_event_r     <= 1'b0;
            timeout_event_r <= 1'b0;
            idle_cnt_r      <= 32'd0;
        end else begin
            state_r         <= state_s;
            entry_bcd_r     <= entry_bcd_s;
            entry_len_r     <= entry_len_s;
            commit_valid_r  <= commit_valid_s;
            commit_bcd_r    <= commit_bcd_s;
            key_event_r     <= key_event_s;
            err_event_r     <= err_event_s;
            timeout_event_r <= timeout_event_s;
            idle_cnt_r      <= idle_cnt_s;
        end
    end

    assign entry_bcd           = entry_bcd_r;
    assign entry_len           = entry_len_r;
    assign commit.commit_valid = commit_valid_r;
    assign commit.commit_bcd   = commit_bcd_r;
    assign key_event           = key_event_r;
    assign err_event           = err_event_r;
    assign timeout_event       = timeout_event_r;
endmodule
